// File: rtl/pipe_stages_pkg.sv
// Shared types for the pipe_stages block: how the stage enables are derived.
package pipe_stages_pkg;

    typedef enum logic {
        ADV_LOCKSTEP = 1'b0,
        ADV_COLLAPSE = 1'b1
    } adv_mode_e;

    function automatic adv_mode_e adv_mode(input int collapse);
        return (collapse != 0) ? ADV_COLLAPSE : ADV_LOCKSTEP;
    endfunction

endpackage

// File: rtl/pipe_stages_stage.sv
// One pipeline slot: valid bit plus payload with load enable and synchronous clear.
module pipe_stage
    import pipe_stages_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic             v_i,
    input  logic [WIDTH-1:0] d_i,
    output logic             v_o,
    output logic [WIDTH-1:0] d_o
);

    logic             v_q, v_d;
    logic [WIDTH-1:0] d_q, d_d;

    // Clear only drops the valid bit; the payload is left as-is.
    always_comb begin
        v_d = v_q;
        d_d = d_q;
        if (clr_i) begin
            v_d = 1'b0;
        end else if (en_i) begin
            v_d = v_i;
            d_d = d_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            v_q <= 1'b0;
            d_q <= '0;
        end else begin
            v_q <= v_d;
            d_q <= d_d;
        end
    end

    assign v_o = v_q;
    assign d_o = d_q;

endmodule

// File: rtl/pipe_stages.sv
// Handshaked register pipeline of DEPTH stages, with optional bubble collapse
// while the output is stalled.
module pipe_stages
    import pipe_stages_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 3,
    parameter int COLLAPSE = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);

    localparam int        OCC_W = $clog2(DEPTH + 1);
    localparam adv_mode_e MODE  = adv_mode(COLLAPSE);

    logic [DEPTH-1:0] v;
    logic [DEPTH-1:0] v_up;
    logic [DEPTH-1:0] v_next;
    logic [DEPTH-1:0] en;
    logic [DEPTH:0]   rdy;
    logic             adv;
    logic [WIDTH-1:0] d    [DEPTH];
    logic [WIDTH-1:0] d_up [DEPTH];
    logic [OCC_W-1:0] occ_q, occ_d;

    function automatic logic [OCC_W-1:0] popcount(input logic [DEPTH-1:0] bits);
        logic [OCC_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            cnt = cnt + OCC_W'(bits[i]);
        end
        return cnt;
    endfunction

    // A stage can take new data if it is empty or its content moves on this cycle.
    always_comb begin
        rdy        = '0;
        rdy[DEPTH] = out_ready;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            rdy[i] = ~v[i] | rdy[i+1];
        end
    end

    assign adv = out_ready | ~v[DEPTH-1];

    always_comb begin
        en = '0;
        for (int i = 0; i < DEPTH; i++) begin
            en[i] = (MODE == ADV_COLLAPSE) ? rdy[i] : adv;
        end
    end

    assign in_ready = (MODE == ADV_COLLAPSE) ? rdy[0] : adv;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        if (i == 0) begin : g_head
            assign v_up[i] = in_valid;
            assign d_up[i] = in_data;
        end else begin : g_body
            assign v_up[i] = v[i-1];
            assign d_up[i] = d[i-1];
        end

        pipe_stage #(
            .WIDTH(WIDTH)
        ) u_stage (
            .clk   (clk),
            .reset (reset),
            .clr_i (flush),
            .en_i  (en[i]),
            .v_i   (v_up[i]),
            .d_i   (d_up[i]),
            .v_o   (v[i]),
            .d_o   (d[i])
        );
    end

    // Occupancy tracks the valid bits the stages will hold after this edge.
    always_comb begin
        v_next = v;
        if (flush) begin
            v_next = '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (en[i]) v_next[i] = v_up[i];
            end
        end
        occ_d = popcount(v_next);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

    assign out_valid = v[DEPTH-1];
    assign out_data  = d[DEPTH-1];
    assign occupancy = occ_q;

endmodule

// File: tb/tb_pipe_stages.sv
// Scenario bench for pipe_stages: scoreboard on the collapsing instance plus
// directed checks on both the collapsing and lockstep instances.
module tb_pipe_stages;

    logic       clk;
    logic       reset;
    logic       flush;
    logic       in_valid, in_ready, out_valid, out_ready;
    logic [7:0] in_data, out_data;
    logic [1:0] occupancy;

    logic       ls_flush;
    logic       ls_in_valid, ls_in_ready, ls_out_valid, ls_out_ready;
    logic [7:0] ls_in_data, ls_out_data;
    logic [1:0] ls_occ;

    int         n_checks;
    int         n_fail;
    logic       mon_en;
    int         occ_m;
    logic [1:0] occ_exp;
    logic [7:0] sb_exp;
    logic       fi, fo;
    logic [7:0] q [$];

    pipe_stages #(.WIDTH(8), .DEPTH(3), .COLLAPSE(1)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy)
    );

    pipe_stages #(.WIDTH(8), .DEPTH(3), .COLLAPSE(0)) dut_ls (
        .clk       (clk),
        .reset     (reset),
        .flush     (ls_flush),
        .in_valid  (ls_in_valid),
        .in_ready  (ls_in_ready),
        .in_data   (ls_in_data),
        .out_valid (ls_out_valid),
        .out_ready (ls_out_ready),
        .out_data  (ls_out_data),
        .occupancy (ls_occ)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    // Scoreboard on the collapsing instance, sampled mid-cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            occ_exp = occ_m[1:0];
            n_checks++;
            if (occupancy !== occ_exp) begin
                n_fail++;
                $display("FAIL sb_occupancy: got %0d expected %0d at %0t", occupancy, occ_exp, $time);
            end
            if (reset || flush) begin
                q.delete();
                occ_m = 0;
            end else begin
                fi = in_valid && in_ready;
                fo = out_valid && out_ready;
                if (fo) begin
                    n_checks++;
                    if (q.size() == 0) begin
                        n_fail++;
                        $display("FAIL sb_unexpected: got data %02h with empty scoreboard at %0t", out_data, $time);
                    end else begin
                        sb_exp = q.pop_front();
                        if (out_data !== sb_exp) begin
                            n_fail++;
                            $display("FAIL sb_data: got %02h expected %02h at %0t", out_data, sb_exp, $time);
                        end
                    end
                end
                if (fi) q.push_back(in_data);
                occ_m = occ_m + (fi ? 1 : 0) - (fo ? 1 : 0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int budget;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        budget    = 0;
        while (occupancy != 2'd0 && budget < 20) begin
            tick();
            budget++;
        end
        tick();
        n_checks++;
        if (occupancy !== 2'd0 || q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: occupancy %0d queue %0d expected 0 and 0", occupancy, q.size());
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || occupancy !== 2'd0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_state: valid %b data %02h occ %0d rdy %b expected 0 00 0 1",
                     out_valid, out_data, occupancy, in_ready);
        end
        n_checks++;
        if (ls_out_valid !== 1'b0 || ls_out_data !== 8'h00 || ls_occ !== 2'd0 || ls_in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_state_ls: valid %b data %02h occ %0d rdy %b expected 0 00 0 1",
                     ls_out_valid, ls_out_data, ls_occ, ls_in_ready);
        end
        occ_m  = 0;
        mon_en = 1'b1;
    endtask

    task automatic test_stream();
        logic [7:0] seq [3];
        seq[0] = 8'h11; seq[1] = 8'h22; seq[2] = 8'h33;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = seq[i];
            tick();
        end
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== seq[i]) begin
                n_fail++;
                $display("FAIL stream_%0d: valid %b data %02h expected 1 %02h", i, out_valid, out_data, seq[i]);
            end
            tick();
        end
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL stream_end: valid %b expected 0", out_valid);
        end
    endtask

    task automatic test_stall_collapse();
        logic [7:0] seq [3];
        seq[0] = 8'hA1; seq[1] = 8'hA2; seq[2] = 8'hA3;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = seq[i];
            n_checks++;
            if (in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL stall_ready_%0d: in_ready %b expected 1", i, in_ready);
            end
            tick();
            n_checks++;
            if (occupancy !== 2'(i + 1)) begin
                n_fail++;
                $display("FAIL stall_occ_%0d: occupancy %0d expected %0d", i, occupancy, i + 1);
            end
        end
        in_data = 8'hA4;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 8'hA1 || occupancy !== 2'd3) begin
                n_fail++;
                $display("FAIL stall_full_%0d: rdy %b valid %b data %02h occ %0d expected 0 1 a1 3",
                         i, in_ready, out_valid, out_data, occupancy);
            end
            tick();
        end
        // Full with downstream ready: pop and push on the same edge.
        in_data   = 8'h5C;
        out_ready = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL passthru_ready: in_ready %b expected 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
        n_checks++;
        if (occupancy !== 2'd3 || out_data !== 8'hA2) begin
            n_fail++;
            $display("FAIL passthru: occ %0d data %02h expected 3 a2", occupancy, out_data);
        end
        drain();
    endtask

    task automatic test_stall_lockstep();
        ls_out_ready = 1'b0;
        ls_in_valid  = 1'b1;
        ls_in_data   = 8'h77;
        tick();
        ls_in_valid = 1'b0;
        tick();
        tick();
        n_checks++;
        if (ls_occ !== 2'd1 || ls_in_ready !== 1'b0 || ls_out_valid !== 1'b1 || ls_out_data !== 8'h77) begin
            n_fail++;
            $display("FAIL ls_stall: occ %0d rdy %b valid %b data %02h expected 1 0 1 77",
                     ls_occ, ls_in_ready, ls_out_valid, ls_out_data);
        end
        ls_in_valid = 1'b1;
        ls_in_data  = 8'h88;
        tick();
        n_checks++;
        if (ls_occ !== 2'd1 || ls_out_data !== 8'h77) begin
            n_fail++;
            $display("FAIL ls_hold: occ %0d data %02h expected 1 77", ls_occ, ls_out_data);
        end
        ls_out_ready = 1'b1;
        #1;
        n_checks++;
        if (ls_in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ls_resume_ready: in_ready %b expected 1", ls_in_ready);
        end
        tick();
        ls_in_valid = 1'b0;
        n_checks++;
        if (ls_occ !== 2'd1 || ls_out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL ls_resume: occ %0d valid %b expected 1 0", ls_occ, ls_out_valid);
        end
        tick();
        tick();
        n_checks++;
        if (ls_out_valid !== 1'b1 || ls_out_data !== 8'h88) begin
            n_fail++;
            $display("FAIL ls_deliver: valid %b data %02h expected 1 88", ls_out_valid, ls_out_data);
        end
        tick();
        n_checks++;
        if (ls_occ !== 2'd0 || ls_out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL ls_empty: occ %0d valid %b expected 0 0", ls_occ, ls_out_valid);
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'hB1;
        tick();
        in_data = 8'hB2;
        tick();
        n_checks++;
        if (occupancy !== 2'd2) begin
            n_fail++;
            $display("FAIL flush_pre: occupancy %0d expected 2", occupancy);
        end
        flush   = 1'b1;
        in_data = 8'hB3;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_ready: in_ready %b expected 1", in_ready);
        end
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        n_checks++;
        if (occupancy !== 2'd0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_clear: occ %0d valid %b expected 0 0", occupancy, out_valid);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++;
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL flush_leak_%0d: valid %b data %02h expected no output", i, out_valid, out_data);
            end
        end
    endtask

    task automatic test_reset_midstream();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = 8'hC0 + 8'(i);
            tick();
        end
        n_checks++;
        if (occupancy !== 2'd3) begin
            n_fail++;
            $display("FAIL midreset_pre: occupancy %0d expected 3", occupancy);
        end
        reset     = 1'b1;
        out_ready = 1'b1;
        in_data   = 8'hCF;
        tick();
        reset    = 1'b0;
        in_valid = 1'b0;
        n_checks++;
        if (out_data !== 8'h00 || out_valid !== 1'b0 || in_ready !== 1'b1 || occupancy !== 2'd0) begin
            n_fail++;
            $display("FAIL midreset: data %02h valid %b rdy %b occ %0d expected 00 0 1 0",
                     out_data, out_valid, in_ready, occupancy);
        end
        tick();
        tick();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_leak: valid %b expected 0", out_valid);
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_data = 8'(8'h40 + i);
            #1;
            n_checks++;
            if (in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b_ready_%0d: in_ready %b expected 1", i, in_ready);
            end
            tick();
        end
        for (int i = 0; i < 80; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            in_data   = 8'($urandom);
            tick();
        end
        drain();
    endtask

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        mon_en       = 1'b0;
        occ_m        = 0;
        reset        = 1'b1;
        flush        = 1'b0;
        in_valid     = 1'b0;
        in_data      = 8'h00;
        out_ready    = 1'b0;
        ls_flush     = 1'b0;
        ls_in_valid  = 1'b0;
        ls_in_data   = 8'h00;
        ls_out_ready = 1'b0;

        test_reset();
        test_stream();
        test_stall_collapse();
        test_stall_lockstep();
        test_flush();
        test_reset_midstream();
        test_back_to_back();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_stages.md
PIPE_STAGES -- requirements
Module: pipe_stages

Interface
REQ-001 Parameter WIDTH, default 8: data bits per stage.
REQ-002 Parameter DEPTH, default 3: number of register stages; legal range 1..16.
REQ-003 Parameter COLLAPSE, default 1: 1 means empty stages fill while downstream is stalled (bubble collapse); 0 means all stages advance in lockstep.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 flush  input  1  synchronous; invalidates all stages at the next edge.
REQ-007 in_valid  input  1  upstream offers in_data.
REQ-008 in_ready  output  1  block accepts in_data this cycle.
REQ-009 in_data  input  WIDTH  upstream payload.
REQ-010 out_valid  output  1  last stage holds valid data.
REQ-011 out_ready  input  1  downstream accepts out_data.
REQ-012 out_data  output  WIDTH  last-stage payload.
REQ-013 occupancy  output  $clog2(DEPTH+1)  count of valid stages.

Function
REQ-014 Each stage i (0 = input side, DEPTH-1 = output side) shall hold a valid bit v[i] and a data word d[i].
REQ-015 Transfer rules: a transfer into stage 0 occurs when in_valid & in_ready; a transfer out occurs when out_valid & out_ready.
REQ-016 COLLAPSE=1 ready chain:
  - rdy[DEPTH] = out_ready
  - rdy[i] = ~v[i] | rdy[i+1]
  - in_ready = rdy[0], purely combinational.
REQ-017 COLLAPSE=0:
  - single advance enable adv = out_ready | ~v[DEPTH-1]
  - in_ready = adv
  - all stages shift together when adv.
REQ-018 On a stage advance, the stage shall load the upstream v and d (stage 0 loads in_valid/in_data); otherwise v and d hold unchanged.
REQ-019 Latency: with out_ready held high, data accepted at edge N shall appear on out_data with out_valid at edge N+DEPTH-1 (visible during the cycle after edge N+DEPTH-1).
REQ-020 Throughput: one transfer per cycle, sustained with no bubbles while out_ready=1.
REQ-021 out_data and out_valid shall stay stable while out_valid=1 and out_ready=0.
REQ-022 Full with out_ready=0: in_ready=0. Full with out_ready=1: in_ready=1, and push and pop occur in the same cycle.
REQ-023 occupancy shall equal the popcount of v, registered alongside v; range 0..DEPTH.
REQ-024 flush has priority over any transfer:
  - all v cleared at the edge
  - an input offered in the flush cycle is discarded
  - d contents are don't-care afterwards
  - in_ready is unaffected by flush.
REQ-025 reset has priority over flush and transfers.
REQ-026 DEPTH=1 shall behave as one handshaked register: in_ready = ~v[0] | out_ready.

Reset
REQ-027 While reset is high at a rising edge, all v and all d shall clear to 0.
REQ-028 After reset: out_valid=0, out_data=0, occupancy=0, in_ready=1.
REQ-029 Reset asserted mid-stream shall drop all in-flight data; no transfer shall complete in the reset cycle.

Structure
REQ-030 No shared-package additions; WIDTH, DEPTH and COLLAPSE shall remain module parameters.
REQ-031 One sub-module, pipe_stage (v/d register with load enable and synchronous clear), shall be instantiated DEPTH times via generate.
REQ-032 Ready-chain and occupancy logic shall live in pipe_stages.

Verification (WIDTH=8, DEPTH=3)
REQ-033 Stream: push 0x11,0x22,0x33 on consecutive edges with out_ready=1 -> out_data 0x11,0x22,0x33 on three consecutive cycles, first one 2 edges after first accept.
REQ-034 Stall, COLLAPSE=1: out_ready=0, push 0xA1 then 0xA2 -> occupancy 1 then 2; 0xA1 held on out_data; in_ready=1 until occupancy=3, then 0.
REQ-035 Stall, COLLAPSE=0: out_ready=0 with last stage valid -> in_ready=0 even though occupancy=1.
REQ-036 Full pass-through: full, out_ready=1, in_valid=1 with 0x5C -> one pop and one push in the same cycle; occupancy stays 3.
REQ-037 Flush: occupancy=2, flush=1 with in_valid=1 -> next cycle occupancy=0, out_valid=0, and the input is not delivered.
REQ-038 Reset mid-stream: occupancy=3, reset=1 -> out_data=0x00, out_valid=0, in_ready=1 next cycle.
